video_ts_render: RTL and testbench
==================================

VIDEO_TS_RENDER -- requirements
Module: video_ts_render

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port tsr_go, input, 1 bit: task strobe from the tile/sprite processor.
REQ-004 SHALL have port tsr_addr, input, 6 bits: graphics column within the bitmap line, in 8-pixel units.
REQ-005 SHALL have port tsr_line, input, 9 bits: bitmap line.
REQ-006 SHALL have port tsr_page, input, 8 bits: first bitmap page.
REQ-007 SHALL have port tsr_x, input, 9 bits: line-buffer X of the task's leftmost pixel.
REQ-008 SHALL have port tsr_xs, input, 3 bits: width code; width is (tsr_xs+1)*8 pixels.
REQ-009 SHALL have port tsr_xf, input, 1 bit: X flip.
REQ-010 SHALL have port tsr_pal, input, 4 bits: palette high nibble.
REQ-011 SHALL have port tsr_rdy, output, 1 bit: renderer is idle and accepts a task.
REQ-012 SHALL have ports dram_addr (output, 21 bits), dram_req (output, 1 bit), dram_next (input, 1 bit), dram_rdata (input, 16 bits): word read port; dram_next marks a cycle with valid dram_rdata.
REQ-013 SHALL have ports lb_waddr (output, 9 bits), lb_wdata (output, 8 bits), lb_we (output, 1 bit): line-buffer pixel write port.

Function
REQ-014 SHALL implement states IDLE, FETCH and DRAIN; tsr_rdy SHALL be 1 only in IDLE.
REQ-015 In IDLE, tsr_go SHALL latch all task inputs and move to FETCH on the next edge; tsr_go outside IDLE SHALL be ignored.
REQ-016 The word count SHALL be (xs+1)*2, giving 2..16 words of 4 pixels at 4 bpp.
REQ-017 For word index w, dram_addr[20:13] SHALL be page + line[8:6] (8-bit wrap).
REQ-018 dram_addr[12:7] SHALL be line[5:0].
REQ-019 dram_addr[6:0] SHALL be {addr,1'b0} + w, wrapping modulo 128.
REQ-020 dram_req SHALL be 1 in FETCH only while the pixel serializer is empty (pix_cnt==0) and words remain.
REQ-021 On dram_next with dram_req=1, the renderer SHALL load the word into the serializer, set pix_cnt=4 and increment w; dram_next with dram_req=0 SHALL be ignored.
REQ-022 The serializer SHALL emit one pixel per cycle while pix_cnt>0, starting the cycle after the load, in nibble order [15:12], [11:8], [7:4], [3:0].
REQ-023 Pixel k (0..width-1) SHALL be written to x+k when xf=0 and to x+width-1-k when xf=1, modulo 512.
REQ-024 lb_wdata SHALL be {pal, nibble}.
REQ-025 lb_we SHALL be 1 only for non-zero nibbles (nibble 0 is transparent); lb_waddr and lb_wdata SHALL still track the pixel.
REQ-026 After the last word is loaded the state SHALL be DRAIN; when its last pixel is emitted the state SHALL return to IDLE on the next edge.
REQ-027 A back-to-back tsr_go is accepted in that IDLE cycle.
REQ-028 Minimum task time SHALL be 1 + words*(1+4) cycles with zero DRAM wait.
REQ-029 DRAM stalls (dram_req=1, dram_next=0) SHALL hold all state with lb_we=0.

Reset
REQ-030 While rst_n=0, and immediately on assertion including mid-task, the state SHALL be IDLE.
REQ-031 While rst_n=0, tsr_rdy SHALL be 1, dram_req=0, lb_we=0, pix_cnt=0, w=0, and dram_addr, lb_waddr and lb_wdata SHALL be 0.
REQ-032 No partial pixel writes SHALL occur after reset release.

Structure
REQ-033 Width constants (LB_AW=9, DRAM_AW=21, PIX_PER_WORD=4) SHALL live in the shared video include file.
REQ-034 Pixel serializer SHALL be sub-module video_ts_pixser (word load, pix_cnt, nibble out).
REQ-035 Total RTL SHALL be about 150-250 lines.

Verification
REQ-036 Task page=0x10, line=0x045, addr=3, xs=0, x=100, xf=0, immediate dram_next -> dram_addr 0x22286 then 0x22287; word 0x1234 writes addr 100..103 with data pal:1..4.
REQ-037 Same task with xf=1 and words 0x1234, 0x5678 -> pixels 1..8 land at x 107 down to 100.
REQ-038 Word 0x0A0B -> lb_we pattern 0,1,0,1 at consecutive X; exactly 2 writes.
REQ-039 xs=7, x=500, addr=63 -> 16 words; dram_addr[6:0] wraps 126, 127, 0..13; X wraps 500..511, 0..51; tsr_rdy returns after last pixel.
REQ-040 rst_n low in the middle of word 3 -> tsr_rdy=1, lb_we=0, dram_req=0 immediately; next task renders correctly.
REQ-041 tsr_go pulsed during FETCH, and dram_next held 0 for 10 cycles -> second task ignored; outputs frozen during the stall; no spurious writes.

Source files
------------

// File: rtl/video_ts_render_pkg.sv
// video_ts_render_pkg
//   Shared widths and state encoding for the tile/sprite line renderer.
//   LB_AW        : line-buffer address width (512 pixels per line)
//   DRAM_AW      : DRAM word-address width
//   PIX_PER_WORD : 4bpp pixels packed in one 16-bit DRAM word
package video_ts_render_pkg;

    localparam int LB_AW        = 9;
    localparam int DRAM_AW      = 21;
    localparam int PIX_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } tsr_state_t;

endpackage

// File: rtl/video_ts_pixser.sv
// video_ts_pixser
//   Pixel serializer: takes one 16-bit word of four 4bpp pixels and emits
//   one nibble per cycle, most significant nibble first.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     load       : capture word and restart the pixel count
//     word       : DRAM word to serialize
//     pix_cnt    : pixels still to emit (0 = empty); the current pixel is
//                  valid whenever pix_cnt != 0
//     nibble     : current pixel value
module video_ts_pixser
    import video_ts_render_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] word,
    output logic [2:0]  pix_cnt,
    output logic [3:0]  nibble
);

    logic [15:0] shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= 3'd0;
        end else if (load) begin
            pix_cnt <= 3'(PIX_PER_WORD);
        end else if (pix_cnt != 3'd0) begin
            pix_cnt <= pix_cnt - 3'd1;
        end
    end

    // Pixel data needs no reset: it is only observed while pix_cnt != 0,
    // which requires a load first.
    always_ff @(posedge clk) begin
        if (load) begin
            shift_q <= word;
        end else if (pix_cnt != 3'd0) begin
            shift_q <= {shift_q[11:0], 4'h0};
        end
    end

    assign nibble = shift_q[15:12];

endmodule

// File: rtl/video_ts_render.sv
// video_ts_render
//   Renders one tile/sprite task (8..64 pixels at 4bpp) from DRAM into the
//   line buffer, with optional horizontal flip and transparent nibble 0.
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     tsr_go, tsr_*              : task strobe and parameters (latched in IDLE)
//     tsr_rdy                    : idle, a task strobe will be accepted
//     dram_addr/req/next/rdata   : word read port, dram_next = data valid
//     lb_waddr/wdata/we          : line-buffer pixel write port
module video_ts_render
    import video_ts_render_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tsr_go,
    input  logic [5:0]         tsr_addr,
    input  logic [8:0]         tsr_line,
    input  logic [7:0]         tsr_page,
    input  logic [8:0]         tsr_x,
    input  logic [2:0]         tsr_xs,
    input  logic               tsr_xf,
    input  logic [3:0]         tsr_pal,
    output logic               tsr_rdy,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_req,
    input  logic               dram_next,
    input  logic [15:0]        dram_rdata,
    output logic [LB_AW-1:0]   lb_waddr,
    output logic [7:0]         lb_wdata,
    output logic               lb_we
);

    tsr_state_t state, state_nxt;

    logic [5:0]  t_addr;
    logic [8:0]  t_line;
    logic [7:0]  t_page;
    logic [8:0]  t_x;
    logic [2:0]  t_xs;
    logic        t_xf;
    logic [3:0]  t_pal;
    logic [4:0]  w;

    logic [4:0]  words;
    logic        accept;
    logic        load;
    logic        last_load;
    logic [2:0]  pix_cnt;
    logic [3:0]  nibble;
    logic        emit;
    logic [6:0]  pix_idx;
    logic [5:0]  last_px;
    logic [8:0]  x_fwd;
    logic [8:0]  x_rev;

    assign words     = {1'b0, t_xs, 1'b0} + 5'd2;
    assign accept    = (state == ST_IDLE) && tsr_go;
    // A new word is fetched only once the previous one has fully drained.
    assign dram_req  = (state == ST_FETCH) && (pix_cnt == 3'd0);
    assign load      = dram_req && dram_next;
    assign last_load = load && ((w + 5'd1) == words);
    assign tsr_rdy   = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (tsr_go) state_nxt = ST_FETCH;
            ST_FETCH: if (last_load) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pix_cnt == 3'd1) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_addr <= '0;
            t_line <= '0;
            t_page <= '0;
            t_x    <= '0;
            t_xs   <= '0;
            t_xf   <= 1'b0;
            t_pal  <= '0;
            w      <= '0;
        end else if (accept) begin
            t_addr <= tsr_addr;
            t_line <= tsr_line;
            t_page <= tsr_page;
            t_x    <= tsr_x;
            t_xs   <= tsr_xs;
            t_xf   <= tsr_xf;
            t_pal  <= tsr_pal;
            w      <= '0;
        end else if (load) begin
            w <= w + 5'd1;
        end
    end

    // Line offset above 63 carries into the page field.
    assign dram_addr = {t_page + {5'b0, t_line[8:6]},
                        t_line[5:0],
                        {t_addr, 1'b0} + {2'b0, w}};

    video_ts_pixser u_pixser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .word    (dram_rdata),
        .pix_cnt (pix_cnt),
        .nibble  (nibble)
    );

    // w has already advanced past the word being emitted, hence w-1.
    assign emit    = (pix_cnt != 3'd0);
    assign pix_idx = {w - 5'd1, 2'b00} + {4'b0, 3'd4 - pix_cnt};
    assign last_px = {t_xs, 3'b111};
    assign x_fwd   = t_x + {2'b0, pix_idx};
    assign x_rev   = t_x + {3'b0, last_px} - {2'b0, pix_idx};

    assign lb_waddr = emit ? (t_xf ? x_rev : x_fwd) : '0;
    assign lb_wdata = emit ? {t_pal, nibble} : 8'h00;
    assign lb_we    = emit && (nibble != 4'h0);

endmodule

// File: tb/tb_video_ts_render.sv
// tb_video_ts_render
//   Randomized bench for video_ts_render with a task-level reference model
//   (expected DRAM addresses and pixel writes computed per task).
module tb_video_ts_render;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tsr_go = 1'b0;
    logic [5:0]  tsr_addr = '0;
    logic [8:0]  tsr_line = '0;
    logic [7:0]  tsr_page = '0;
    logic [8:0]  tsr_x = '0;
    logic [2:0]  tsr_xs = '0;
    logic        tsr_xf = 1'b0;
    logic [3:0]  tsr_pal = '0;
    logic        tsr_rdy;
    logic [20:0] dram_addr;
    logic        dram_req;
    logic        dram_next = 1'b0;
    logic [15:0] dram_rdata = '0;
    logic [8:0]  lb_waddr;
    logic [7:0]  lb_wdata;
    logic        lb_we;

    int n_checks = 0;
    int n_errs   = 0;
    logic [15:0] wbuf [16];

    video_ts_render dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tsr_go     (tsr_go),
        .tsr_addr   (tsr_addr),
        .tsr_line   (tsr_line),
        .tsr_page   (tsr_page),
        .tsr_x      (tsr_x),
        .tsr_xs     (tsr_xs),
        .tsr_xf     (tsr_xf),
        .tsr_pal    (tsr_pal),
        .tsr_rdy    (tsr_rdy),
        .dram_addr  (dram_addr),
        .dram_req   (dram_req),
        .dram_next  (dram_next),
        .dram_rdata (dram_rdata),
        .lb_waddr   (lb_waddr),
        .lb_wdata   (lb_wdata),
        .lb_we      (lb_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) begin
            v[i*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        end
        return v;
    endfunction

    // Runs one task to completion. stall_first holds off the first request
    // for that many cycles; stall_pct adds random stalls; noise pulses
    // tsr_go with junk parameters while busy.
    task automatic run_task(input logic [7:0] page, input logic [8:0] line,
                            input logic [5:0] addr, input logic [8:0] x,
                            input logic [2:0] xs, input logic xf,
                            input logic [3:0] pal, input int stall_pct,
                            input int stall_first, input bit noise);
        int words, width, wi, busy, stalls, nwr, exp_wr, hold;
        int nib, px;
        logic [8:0] eaddr[$];
        logic [7:0] edata[$];
        logic [31:0] exp_da;
        words = (int'(xs) + 1) * 2;
        width = words * 4;
        wi = 0; busy = 0; stalls = 0; nwr = 0; exp_wr = 0; hold = stall_first;
        for (int k = 0; k < width; k++) begin
            nib = (int'(wbuf[k / 4]) >> (12 - 4 * (k % 4))) & 15;
            px  = xf ? (int'(x) + width - 1 - k) % 512 : (int'(x) + k) % 512;
            if (nib != 0) begin
                eaddr.push_back(9'(px));
                edata.push_back({pal, 4'(nib)});
                exp_wr++;
            end
        end

        chk("rdy_before", 32'(tsr_rdy), 32'd1);
        tsr_page = page; tsr_line = line; tsr_addr = addr; tsr_x = x;
        tsr_xs = xs; tsr_xf = xf; tsr_pal = pal; tsr_go = 1'b1;
        @(negedge clk);
        tsr_go = 1'b0;

        while (!tsr_rdy && busy < 2000) begin
            busy++;
            if (noise && $urandom_range(0, 5) == 0) begin
                tsr_go = 1'b1;
                tsr_x = 9'($urandom); tsr_xf = 1'($urandom);
                tsr_pal = 4'($urandom); tsr_addr = 6'($urandom);
            end else begin
                tsr_go = 1'b0;
            end
            if (lb_we) begin
                nwr++;
                if (eaddr.size() == 0) begin
                    chk("extra_write", 32'd1, 32'd0);
                end else begin
                    chk("wr_addr", 32'(lb_waddr), 32'(eaddr.pop_front()));
                    chk("wr_data", 32'(lb_wdata), 32'(edata.pop_front()));
                end
            end
            if (dram_req) begin
                exp_da = (((int'(page) + int'(line) / 64) % 256) << 13)
                       | ((int'(line) % 64) << 7)
                       | ((int'(addr) * 2 + wi) % 128);
                chk("dram_addr", 32'(dram_addr), exp_da);
                if (hold > 0 || wi >= words || $urandom_range(0, 99) < stall_pct) begin
                    if (hold > 0) hold--;
                    dram_next = 1'b0;
                    stalls++;
                    chk("stall_we", 32'(lb_we), 32'd0);
                end else begin
                    dram_next  = 1'b1;
                    dram_rdata = wbuf[wi];
                    wi++;
                end
            end else begin
                // Data strobes without a request must be ignored.
                dram_next  = ($urandom_range(0, 3) == 0);
                dram_rdata = 16'($urandom);
            end
            @(negedge clk);
        end
        tsr_go = 1'b0;
        dram_next = 1'b0;
        if (busy >= 2000) chk("timeout", 32'd0, 32'd1);
        chk("words_fetched", 32'(wi), 32'(words));
        chk("write_count", 32'(nwr), 32'(exp_wr));
        chk("task_cycles", 32'(busy), 32'(words * 5 + stalls));
    endtask

    initial begin
        int cyc;
        int loads;

        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(tsr_rdy), 32'd1);
        chk("rst_req", 32'(dram_req), 32'd0);
        chk("rst_we", 32'(lb_we), 32'd0);
        chk("rst_daddr", 32'(dram_addr), 32'd0);
        chk("rst_waddr", 32'(lb_waddr), 32'd0);
        chk("rst_wdata", 32'(lb_wdata), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic forward task
        wbuf[0] = 16'h1234; wbuf[1] = 16'h0000;
        run_task(8'h10, 9'h045, 6'd3, 9'd100, 3'd0, 1'b0, 4'hA, 0, 0, 1'b0);

        // Flipped task
        wbuf[0] = 16'h1234; wbuf[1] = 16'h5678;
        run_task(8'h10, 9'h045, 6'd3, 9'd100, 3'd0, 1'b1, 4'h5, 0, 0, 1'b0);

        // Transparency
        wbuf[0] = 16'h0A0B; wbuf[1] = 16'h0000;
        run_task(8'h22, 9'h001, 6'd0, 9'd40, 3'd0, 1'b0, 4'h3, 0, 0, 1'b0);

        // Widest task with address and X wrap
        for (int i = 0; i < 16; i++) wbuf[i] = rand_word();
        run_task(8'hFF, 9'h1C0, 6'd63, 9'd500, 3'd7, 1'b0, 4'hC, 0, 0, 1'b0);

        // Long stall with go pulses while busy
        for (int i = 0; i < 16; i++) wbuf[i] = rand_word();
        run_task(8'h04, 9'h0FF, 6'd10, 9'd200, 3'd1, 1'b0, 4'h7, 10, 10, 1'b1);

        // Reset in the middle of word 3
        for (int i = 0; i < 16; i++) wbuf[i] = 16'hFFFF;
        tsr_page = 8'h33; tsr_line = 9'h077; tsr_addr = 6'd5; tsr_x = 9'd10;
        tsr_xs = 3'd3; tsr_xf = 1'b0; tsr_pal = 4'h9; tsr_go = 1'b1;
        @(negedge clk);
        tsr_go = 1'b0;
        cyc = 0; loads = 0;
        while (cyc < 200 && !(loads == 3 && dram_req == 1'b0 && lb_we == 1'b1
                              && lb_waddr == 9'd19)) begin
            cyc++;
            dram_next  = dram_req;
            dram_rdata = 16'hFFFF;
            if (dram_req) loads++;
            @(negedge clk);
        end
        dram_next = 1'b0;
        if (cyc >= 200) chk("mid_reset_reach", 32'd0, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", 32'(tsr_rdy), 32'd1);
        chk("midrst_we", 32'(lb_we), 32'd0);
        chk("midrst_req", 32'(dram_req), 32'd0);
        chk("midrst_waddr", 32'(lb_waddr), 32'd0);
        @(negedge clk);
        chk("midrst_hold_rdy", 32'(tsr_rdy), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_we", 32'(lb_we), 32'd0);
        for (int i = 0; i < 16; i++) wbuf[i] = rand_word();
        run_task(8'h01, 9'h002, 6'd4, 9'd300, 3'd2, 1'b1, 4'h2, 0, 0, 1'b0);

        // Random tasks
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 16; i++) wbuf[i] = rand_word();
            run_task(8'($urandom), 9'($urandom), 6'($urandom), 9'($urandom),
                     3'($urandom), 1'($urandom), 4'($urandom),
                     $urandom_range(0, 40), $urandom_range(0, 3), 1'b1);
            // Back-to-back: start the next task right in the first idle cycle
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
